uart_rx_param: RTL and testbench

//  Parametrised UART receiver: next generation of the fixed 16-bit receiver. Adds configurable

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_fifo.sv | 38 +++
 rtl/uart_rx_param.sv | 121 ++++++++++++
 tb/tb_uart_rx_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, stop-bit constants and parity helper for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int STOP_1 = 1;
  localparam int STOP_2 = 2;
  function automatic logic parity_bad(input logic [15:0] d, input logic p, input logic odd);
    return (^{d, p}) != odd;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO; head word is presented combinationally
module uart_rx_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk_50m,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_50m)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity/framing/overrun flags and receive FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = STOP_1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50m,
  input  logic                          rst,
  input  logic                          clken,
  input  logic                          rx_en,
  input  logic                          Rx,
  input  logic                          rd_en,
  input  logic                          ovr_clr,
  output logic [DATA_BITS-1:0]          data,
  output logic                          valid,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  rx_state_t state;
  logic rx_s1, rx_s2, ferr, pbad, push_r, full, empty, pop, centre;
  logic [SW-1:0] sample_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS+1:0] push_word, head;
  assign centre = sample_cnt == S_LAST;
  assign pop = rd_en & ~empty;
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) {rx_s2, rx_s1} <= 2'b11;
    else {rx_s2, rx_s1} <= {rx_s1, Rx};
  // sample_cnt wraps at OVERSAMPLE, so after the half-bit start check every wrap is a bit centre
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) begin
      state <= IDLE;
      sample_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      ferr <= 1'b0;
      pbad <= 1'b0;
      push_r <= 1'b0;
      push_word <= '0;
    end else begin
      push_r <= 1'b0;
      if (!rx_en) begin
        state <= IDLE;
        sample_cnt <= '0;
        bit_cnt <= '0;
      end else if (clken) begin
        sample_cnt <= sample_cnt + 1'b1;
        case (state)
          IDLE: begin
            sample_cnt <= '0;
            if (!rx_s2) state <= START;
          end
          START:
            if (sample_cnt == S_HALF) begin
              sample_cnt <= '0;
              bit_cnt <= '0;
              ferr <= 1'b0;
              pbad <= 1'b0;
              state <= rx_s2 ? IDLE : DATA;
            end
          DATA:
            if (centre) begin
              shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == B_LAST) state <= PARITY_EN != 0 ? PARITY : STOP;
            end
          PARITY:
            if (centre) begin
              pbad <= parity_bad(16'(shreg), rx_s2, 1'(PARITY_ODD));
              state <= STOP;
            end
          STOP:
            if (centre) begin
              ferr <= ferr | ~rx_s2;
              bit_cnt <= bit_cnt == STOP_LAST ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == STOP_LAST) begin
                push_r <= 1'b1;
                push_word <= {shreg, ferr | ~rx_s2, pbad};
                state <= rx_s2 ? IDLE : BREAK;
              end
            end
          BREAK: begin
            sample_cnt <= '0;
            if (rx_s2) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) overrun <= 1'b0;
    else if (push_r & full & ~pop) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  uart_rx_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_50m(clk_50m),
    .rst(rst),
    .push(push_r),
    .pop(pop),
    .din(push_word),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign {data, frame_err, parity_err} = head;
  assign valid = ~empty;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for the UART receiver (8-bit even parity and 16-bit two-stop builds)
module tb_uart_rx_param;
  logic clk_50m = 1'b0;
  logic clken = 1'b0;
  logic rst, rx_en, Rx, Rx2, man_rd, mon_rd, auto_rd, ovr_clr, rd_en, rd_en2;
  logic [7:0] data;
  logic valid, frame_err, parity_err, overrun;
  logic [2:0] fifo_count;
  logic [15:0] data2;
  logic valid2, frame_err2, parity_err2, overrun2;
  logic [2:0] fifo_count2;
  logic [9:0] q1 [$];
  logic [17:0] q2 [$];
  int passed = 0;
  int total = 0;
  bit hit;

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) clken <= ~clken;
  assign rd_en = auto_rd ? mon_rd : man_rd;
  assign rd_en2 = valid2;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx_en(rx_en), .Rx(Rx), .rd_en(rd_en),
    .ovr_clr(ovr_clr), .data(data), .valid(valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .fifo_count(fifo_count));

  uart_rx_param #(.DATA_BITS(16), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx_en(rx_en), .Rx(Rx2), .rd_en(rd_en2),
    .ovr_clr(ovr_clr), .data(data2), .valid(valid2), .frame_err(frame_err2),
    .parity_err(parity_err2), .overrun(overrun2), .fifo_count(fifo_count2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk_50m iff clken);
    #1;
  endtask

  task automatic frame8(input logic [7:0] d, input logic pb, input logic stp,
                        input logic fe, input logic pe, input bit exp);
    if (exp) q1.push_back({d, fe, pe});
    Rx = 1'b0; tk(16);
    for (int i = 0; i < 8; i++) begin Rx = d[i]; tk(16); end
    Rx = pb; tk(16);
    Rx = stp; tk(16);
    if (stp) tk(4);
  endtask

  task automatic frame16(input logic [15:0] d, input logic s1, input logic s2, input logic fe);
    q2.push_back({d, fe, 1'b0});
    Rx2 = 1'b0; tk(16);
    for (int i = 0; i < 16; i++) begin Rx2 = d[i]; tk(16); end
    Rx2 = s1; tk(16);
    Rx2 = s2; tk(16);
    if (s2) tk(4);
  endtask

  task automatic drain1;
    for (int i = 0; i < 3000; i++) begin
      if (q1.size() == 0 && !valid) break;
      @(negedge clk_50m);
    end
    chk("drain1_left", q1.size(), 0);
  endtask

  always @(negedge clk_50m) begin
    mon_rd = 1'b0;
    if (auto_rd && valid) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL sb1: unexpected word %0h, none required", {data, frame_err, parity_err});
      end else chk("sb1", {data, frame_err, parity_err}, q1.pop_front());
      mon_rd = 1'b1;
    end
  end

  always @(negedge clk_50m)
    if (valid2) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL sb2: unexpected word %0h, none required", {data2, frame_err2, parity_err2});
      end else chk("sb2", {data2, frame_err2, parity_err2}, q2.pop_front());
    end

  initial begin
    rst = 1'b1; Rx = 1'b1; Rx2 = 1'b1; rx_en = 1'b1;
    man_rd = 1'b0; auto_rd = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk_50m);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", data, 0);
    chk("rst_flags", {frame_err, parity_err}, 0);
    rst = 1'b0;
    tk(4);
    // basic frame, left in the FIFO for a direct look
    frame8(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    chk("t1_valid", valid, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_data", data, 8'hA5);
    chk("t1_flags", {frame_err, parity_err}, 0);
    auto_rd = 1'b1;
    drain1();
    // false start
    Rx = 1'b0; tk(6); Rx = 1'b1; tk(20);
    chk("t2_no_push", fifo_count, 0);
    frame8(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drain1();
    // parity error, framing error with break, clean recovery
    frame8(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    frame8(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    tk(24); Rx = 1'b1; tk(20);
    frame8(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drain1();
    // overrun
    auto_rd = 1'b0;
    frame8(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_count", fifo_count, 4);
    chk("t4_overrun", overrun, 1);
    chk("t4_head", data, 8'h11);
    ovr_clr = 1'b1;
    @(posedge clk_50m); #1;
    ovr_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    auto_rd = 1'b1;
    drain1();
    // push and pop on a full FIFO in the same cycle
    auto_rd = 1'b0;
    frame8(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h24, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    frame8(8'h18, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    hit = 1'b0;
    fork
      frame8(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      begin
        for (int i = 0; i < 1000 && !hit; i++) begin
          @(negedge clk_50m);
          if (dut.push_r) hit = 1'b1;
        end
        if (hit) begin
          man_rd = 1'b1;
          @(posedge clk_50m); #1;
          man_rd = 1'b0;
          void'(q1.pop_front());
        end
      end
    join
    chk("t5_push_seen", hit, 1);
    chk("t5_count", fifo_count, 4);
    chk("t5_overrun", overrun, 0);
    chk("t5_head", data, 8'h42);
    auto_rd = 1'b1;
    drain1();
    // reset mid-frame discards FIFO contents and the partial frame
    auto_rd = 1'b0;
    frame8(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("t6_pre_valid", valid, 1);
    Rx = 1'b0; tk(16);
    Rx = 1'b1; tk(48);
    rst = 1'b1;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_data", data, 0);
    tk(4);
    rst = 1'b0;
    tk(4);
    auto_rd = 1'b1;
    frame8(8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drain1();
    // 16-bit build with two stop bits
    frame16(16'hBEEF, 1'b1, 1'b1, 1'b0);
    frame16(16'h1234, 1'b1, 1'b0, 1'b1);
    tk(20); Rx2 = 1'b1; tk(20);
    for (int i = 0; i < 3000; i++) begin
      if (q2.size() == 0 && !valid2) break;
      @(negedge clk_50m);
    end
    chk("drain2_left", q2.size(), 0);
    chk("end_count", fifo_count, 0);
    chk("end_count2", fifo_count2, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
